// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, baud divisor lookup and receiver state enum
// Optional parity state is compiled in only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int OS_RATE        = 16;
    localparam int NUM_BAUD_CODES = 10;

    // Clk cycles per oversample tick, indexed by baud code (1200 .. 115200 baud)
    localparam logic [9:0] BAUD_DIV [NUM_BAUD_CODES] = '{
        10'd768, 10'd384, 10'd192, 10'd96, 10'd64,
        10'd48,  10'd32,  10'd24,  10'd16, 10'd8
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_t;

    function automatic logic baud_code_valid(input logic [3:0] code);
        return code < 4'(NUM_BAUD_CODES);
    endfunction

    // Invalid codes return 0, which the tick generator treats as "never tick".
    function automatic logic [9:0] baud_div(input logic [3:0] code);
        if (baud_code_valid(code)) begin
            return BAUD_DIV[code];
        end
        return 10'd0;
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// rtl/uart_os_tick.sv - oversample tick generator: one-cycle enable every baud_div(code) Clk cycles
// Shared between the UART receiver and transmitter.
module uart_os_tick
    import uart_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_baud_code,
    input  logic       i_clear,
    input  logic       i_enable,
    output logic       o_tick
);

    logic [9:0] r_cnt;
    logic [9:0] w_div;
    logic       w_wrap;

    assign w_div  = baud_div(i_baud_code);
    assign w_wrap = (w_div != 10'd0) && (r_cnt == w_div - 10'd1);
    assign o_tick = i_enable && !i_clear && w_wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            if (w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 10'd1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampling UART receiver with valid/ready byte output
// Define UART_RX_PARITY_EN for an even-parity bit and the Parity_err pulse output.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
)
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Baud_select,
    input  logic       Rx,
    input  logic       Rd_ready,
    output logic [7:0] Rd_data,
    output logic       Rd_valid,
    output logic       Frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       Overrun,
    output logic       Parity_err
`else
    output logic       Overrun
`endif
);

    localparam logic [3:0] OS_MID   = 4'(OS_RATE / 2 - 1);
    localparam logic [3:0] OS_LAST  = 4'(OS_RATE - 1);
    localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rx_prev;
    logic [3:0]           r_code;
    logic [3:0]           r_os_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_break;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_tick;
    logic w_fall;
    logic w_mid_bit;
    logic w_bit_end;
    logic w_os_clear;
    logic w_start_frame;
    logic w_shift_en;
    logic w_byte_done;
    logic w_stop_bad;
    logic w_par_chk;
    logic w_drop;

    assign w_fall     = r_rx_prev && !r_sync2;
    assign w_mid_bit  = w_tick && (r_os_cnt == OS_MID);
    assign w_bit_end  = w_tick && (r_os_cnt == OS_LAST);
    assign w_os_clear = (r_state == ST_IDLE);
    assign w_drop     = w_byte_done && r_valid && !Rd_ready;

    uart_os_tick u_os_tick (
        .i_clk       (Clk),
        .i_rst_n     (Reset),
        .i_baud_code (r_code),
        .i_clear     (w_os_clear),
        .i_enable    (!w_os_clear),
        .o_tick      (w_tick)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start_frame = 1'b0;
        w_shift_en    = 1'b0;
        w_byte_done   = 1'b0;
        w_stop_bad    = 1'b0;
        w_par_chk     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && baud_code_valid(Baud_select)) begin
                    w_start_frame = 1'b1;
                    w_state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (w_mid_bit) begin
                    w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_par_chk   = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // After a low stop bit, hold here until the line releases (break).
                if (r_break) begin
                    if (r_sync2) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_bit_end) begin
                    if (r_sync2) begin
                        w_byte_done = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_bad = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_code    <= '0;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_break   <= 1'b0;
        end else begin
            r_sync1   <= Rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            if (w_start_frame) begin
                r_code <= Baud_select;
            end
            // Realign to bit boundaries once the start bit is confirmed at mid-bit.
            if (w_os_clear || (r_state == ST_START && w_mid_bit)) begin
                r_os_cnt <= '0;
            end else if (w_tick) begin
                r_os_cnt <= r_os_cnt + 4'd1;
            end
            if (w_os_clear) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_shift   <= {r_sync2, r_shift[DATA_BITS-1:1]};
            end
            if (w_stop_bad) begin
                r_break <= 1'b1;
            end else if (w_state_nxt == ST_IDLE) begin
                r_break <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_drop;
            if (w_byte_done && !w_drop) begin
                r_data  <= 8'(r_shift);
                r_valid <= 1'b1;
            end else if (r_valid && Rd_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_par_chk && (r_sync2 != ^r_shift);
        end
    end

    assign Parity_err = r_parity_err;
`endif

    assign Rd_data   = r_data;
    assign Rd_valid  = r_valid;
    assign Frame_err = r_frame_err;
    assign Overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed frames against a frame-level receiver model
module tb_uart_rx_core;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] Baud_select;
    logic       Rx;
    logic       Rd_ready;
    logic [7:0] Rd_data;
    logic       Rd_valid;
    logic       Frame_err;
    logic       Overrun;
`ifdef UART_RX_PARITY_EN
    logic       Parity_err;
    logic       g_par_flip = 1'b0;
    int         n_perr = 0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t_fall = 0;
    int last_lat = 0;
    int n_rise = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int exp_rise = 0;
    int exp_ferr = 0;
    int exp_ovr = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_pending = 1'b0;

    uart_rx_core #(.DATA_BITS(8)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Baud_select (Baud_select),
        .Rx          (Rx),
        .Rd_ready    (Rd_ready),
        .Rd_data     (Rd_data),
        .Rd_valid    (Rd_valid),
        .Frame_err   (Frame_err),
`ifdef UART_RX_PARITY_EN
        .Overrun     (Overrun),
        .Parity_err  (Parity_err)
`else
        .Overrun     (Overrun)
`endif
    );

    initial forever #5 Clk = ~Clk;

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Frame-level model: decide the fate of a frame from the handshake state at send time.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (m_pending && !Rd_ready) begin
            exp_ovr++;
        end else begin
            m_byte = b;
            exp_rise++;
            if (!Rd_ready) m_pending = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_frame(input int bc, input logic [7:0] b, input logic stop);
        Rx = 1'b0;
        t_fall = cyc;
        idle(bc);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            idle(bc);
        end
`ifdef UART_RX_PARITY_EN
        Rx = (^b) ^ g_par_flip;
        idle(bc);
`endif
        Rx = stop;
        idle(bc);
        Rx = 1'b1;
    endtask

    task automatic consume();
        Rd_ready = 1'b1;
        @(negedge Clk);
        Rd_ready = 1'b0;
        m_pending = 1'b0;
        check("valid_cleared_after_accept", int'(Rd_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, int'(Rd_valid), 0);
        check({tag, "_rd_data"}, int'(Rd_data), 0);
        check({tag, "_frame_err"}, int'(Frame_err), 0);
        check({tag, "_overrun"}, int'(Overrun), 0);
    endtask

    initial begin : compare
        logic prev_valid;
        int   ferr_w;
        int   ovr_w;
        prev_valid = 1'b0;
        ferr_w = 0;
        ovr_w = 0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                if (Rd_valid) check("rd_data_vs_model", int'(Rd_data), int'(m_byte));
                if (Rd_valid && !prev_valid) begin
                    n_rise++;
                    last_lat = cyc - t_fall;
                end
                if (Frame_err) begin
                    n_ferr++;
                    ferr_w++;
                end else begin
                    if (ferr_w > 0) check("frame_err_width", ferr_w, 1);
                    ferr_w = 0;
                end
                if (Overrun) begin
                    n_ovr++;
                    ovr_w++;
                end else begin
                    if (ovr_w > 0) check("overrun_width", ovr_w, 1);
                    ovr_w = 0;
                end
`ifdef UART_RX_PARITY_EN
                if (Parity_err) n_perr++;
`endif
            end
            prev_valid = Rd_valid;
        end
    end

    initial begin
        Reset = 1'b0;
        Rx = 1'b1;
        Rd_ready = 1'b0;
        Baud_select = 4'd9;
        idle(3);
        check_reset_outputs("por");
        Reset = 1'b1;
        idle(20);

        model_frame(8'hA5, 1'b1);
        send_frame(128, 8'hA5, 1'b1);
        idle(10);
        check("a5_rise", n_rise, exp_rise);
        check("a5_data", int'(Rd_data), 'hA5);
        check("a5_valid_held", int'(Rd_valid), 1);
        check_range("a5_latency", last_lat, 1214, 1226);
        consume();

        Rx = 1'b0;
        t_fall = cyc;
        idle(40);
        Rx = 1'b1;
        idle(1500);
        check("false_start_rise", n_rise, exp_rise);
        check("false_start_ferr", n_ferr, exp_ferr);
        model_frame(8'h5A, 1'b1);
        send_frame(128, 8'h5A, 1'b1);
        idle(10);
        check("after_false_start_data", int'(Rd_data), 'h5A);
        consume();

        model_frame(8'h3C, 1'b0);
        send_frame(128, 8'h3C, 1'b0);
        idle(10);
        check("stop_low_ferr", n_ferr, exp_ferr);
        check("stop_low_rise", n_rise, exp_rise);
        check("stop_low_valid", int'(Rd_valid), 0);
        idle(256);
        model_frame(8'h55, 1'b1);
        send_frame(128, 8'h55, 1'b1);
        idle(10);
        check("after_ferr_data", int'(Rd_data), 'h55);
        consume();

        Baud_select = 4'd12;
        send_frame(128, 8'h81, 1'b1);
        idle(300);
        check("invalid_code_rise", n_rise, exp_rise);
        Baud_select = 4'd9;
        idle(20);

        Rd_ready = 1'b1;
        model_frame(8'h0F, 1'b1);
        send_frame(128, 8'h0F, 1'b1);
        model_frame(8'hF0, 1'b1);
        fork
            send_frame(128, 8'hF0, 1'b1);
            begin
                idle(128 * 3);
                Baud_select = 4'd8;
            end
        join
        idle(10);
        Rd_ready = 1'b0;
        Baud_select = 4'd9;
        check("back_to_back_rise", n_rise, exp_rise);
        check_range("baud_change_latency", last_lat, 1214, 1226);
        check("back_to_back_valid", int'(Rd_valid), 0);

        Baud_select = 4'd8;
        model_frame(8'h11, 1'b1);
        send_frame(256, 8'h11, 1'b1);
        idle(10);
        check_range("code8_latency", last_lat, 2430, 2442);
        model_frame(8'h22, 1'b1);
        send_frame(256, 8'h22, 1'b1);
        idle(10);
        check("overrun_count", n_ovr, exp_ovr);
        check("overrun_kept_data", int'(Rd_data), 'h11);
        check("overrun_valid", int'(Rd_valid), 1);

        Baud_select = 4'd3;
        fork
            send_frame(1536, 8'h96, 1'b1);
            begin
                idle(1536 * 5 + 768);
                Reset = 1'b0;
                #1;
                check_reset_outputs("mid_reset");
            end
        join
        m_pending = 1'b0;
        Reset = 1'b1;
        idle(20);
        model_frame(8'h7E, 1'b1);
        send_frame(1536, 8'h7E, 1'b1);
        idle(10);
        check("after_reset_data", int'(Rd_data), 'h7E);
        check("after_reset_valid", int'(Rd_valid), 1);
        consume();

`ifdef UART_RX_PARITY_EN
        Baud_select = 4'd9;
        g_par_flip = 1'b1;
        model_frame(8'h01, 1'b1);
        send_frame(128, 8'h01, 1'b1);
        g_par_flip = 1'b0;
        idle(10);
        check("parity_err_count", n_perr, 1);
        check("parity_err_data", int'(Rd_data), 'h01);
        check("parity_err_valid", int'(Rd_valid), 1);
        consume();
`endif

        check("total_rises", n_rise, exp_rise);
        check("total_frame_err", n_ferr, exp_ferr);
        check("total_overrun", n_ovr, exp_ovr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
